// File: rtl/mul8_seq_pkg.sv
// Shared constants and state encoding for the nibble-ROM based 8x8 multiplier.
package mul8_seq_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift applied to partial products lo*lo, lo*hi, hi*lo, hi*hi.
    localparam int unsigned PP_SHIFT [4] = '{0, 4, 4, 8};

endpackage

// File: rtl/mul8_rom_top.sv
// Wrapper pairing the multiplier sequencer with its dedicated product ROM.
module mul8_rom_top
    import mul8_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    logic [OP_W-1:0] rom_addr;
    logic [OP_W-1:0] rom_data;

    mul8_seq #(.ROM_LAT(1)) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    rom_256x8 u_rom (
        .clka  (clk),
        .addra (rom_addr),
        .douta (rom_data)
    );

endmodule

// File: rtl/rom_256x8.sv
// 4x4 product ROM: douta = addra[7:4] * addra[3:0], one-cycle read latency.
module rom_256x8 (
    input  logic       clka,
    input  logic [7:0] addra,
    output logic [7:0] douta
);

    always_ff @(posedge clka) begin
        douta <= 8'(addra[7:4]) * 8'(addra[3:0]);
    end

endmodule

// File: rtl/mul8_seq.sv
// Sequential unsigned 8x8 multiplier: four 4x4 ROM lookups, shift-accumulated,
// with valid/ready handshakes on both operand and result sides.
module mul8_seq
    import mul8_seq_pkg::*;
#(
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy,
    output logic [OP_W-1:0]   rom_addr,
    input  logic [OP_W-1:0]   rom_data
);

    localparam logic [2:0] K_LAST = 3'(3 + ROM_LAT);

    state_t state, state_next;

    logic [2:0]        k;
    logic [OP_W-1:0]   a_r, b_r;
    logic [PROD_W-1:0] acc, acc_next, term;
    logic              issue;
    logic [3:0]        issue_sh;
    logic [ROM_LAT-1:0] tag_v;
    logic [3:0]        tag_sh [ROM_LAT];

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        unique case (k)
            3'd0:    rom_addr = {a_r[NIB_W-1:0],    b_r[NIB_W-1:0]};
            3'd1:    rom_addr = {a_r[NIB_W-1:0],    b_r[OP_W-1:NIB_W]};
            3'd2:    rom_addr = {a_r[OP_W-1:NIB_W], b_r[NIB_W-1:0]};
            default: rom_addr = {a_r[OP_W-1:NIB_W], b_r[OP_W-1:NIB_W]};
        endcase
    end

    // The tag pipeline tracks which lookup is on rom_data this cycle.
    always_comb begin
        issue    = (state == RUN) && (k <= 3'd3);
        issue_sh = 4'(PP_SHIFT[k[1:0]]);
        term     = PROD_W'(rom_data) << tag_sh[ROM_LAT-1];
        acc_next = tag_v[ROM_LAT-1] ? (acc + term) : acc;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (k == K_LAST) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            k         <= '0;
            acc       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            tag_v     <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) tag_sh[i] <= '0;
        end else begin
            out_valid <= (state_next == DONE);
            tag_v[0]  <= issue;
            tag_sh[0] <= issue_sh;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_sh[i] <= tag_sh[i-1];
            end
            unique case (state)
                IDLE: if (in_valid) begin
                    a_r <= a;
                    b_r <= b;
                    k   <= '0;
                    acc <= '0;
                end
                RUN: begin
                    acc <= acc_next;
                    if (k == K_LAST) product <= acc_next;
                    else             k       <= k + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq with behavioural ROMs of latency 1 and 2.
module tb_mul8_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [7:0] a1, b1, rom_addr1, rom_data1;
    logic [15:0] product1;
    logic in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [7:0] a2, b2, rom_addr2, rom_data2, rom_q2;
    logic [15:0] product2;

    int checks = 0;
    int errors = 0;

    mul8_seq #(.ROM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .product(product1), .busy(busy1), .rom_addr(rom_addr1), .rom_data(rom_data1)
    );

    mul8_seq #(.ROM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .product(product2), .busy(busy2), .rom_addr(rom_addr2), .rom_data(rom_data2)
    );

    function automatic logic [7:0] rom_lookup(input logic [7:0] addr);
        int x, y;
        x = int'(addr[7:4]);
        y = int'(addr[3:0]);
        return 8'(x * y);
    endfunction

    initial begin
        rom_data1 = '0;
        rom_data2 = '0;
        rom_q2    = '0;
    end
    always @(posedge clk) rom_data1 <= rom_lookup(rom_addr1);
    always @(posedge clk) begin
        rom_q2    <= rom_lookup(rom_addr2);
        rom_data2 <= rom_q2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic v, input logic [7:0] x, input logic [7:0] y);
        if (s) begin in_valid2 = v; a2 = x; b2 = y; end
        else   begin in_valid1 = v; a1 = x; b1 = y; end
    endtask

    task automatic set_ready(input bit s, input logic r);
        if (s) out_ready2 = r;
        else   out_ready1 = r;
    endtask

    function automatic logic ov(input bit s);
        return s ? out_valid2 : out_valid1;
    endfunction

    function automatic logic ir(input bit s);
        return s ? in_ready2 : in_ready1;
    endfunction

    function automatic logic [15:0] prod(input bit s);
        return s ? product2 : product1;
    endfunction

    // Accept one pair, scramble a/b afterwards, count edges to out_valid, then handshake.
    task automatic do_txn(input bit s, input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] p, output int lat);
        int n;
        drive(s, 1'b1, x, y);
        set_ready(s, 1'b1);
        n = 0;
        while (!ir(s) && n < 30) begin tick; n++; end
        tick;
        drive(s, 1'b0, 8'($urandom), 8'($urandom));
        lat = 0;
        while (!ov(s) && lat < 30) begin tick; lat++; end
        p = prod(s);
        tick;
    endtask

    task automatic wait_ov(input bit s);
        int n;
        n = 0;
        while (!ov(s) && n < 30) begin tick; n++; end
        checks++;
        if (!ov(s)) begin errors++; $display("FAIL wait_out_valid got 0 exp 1 (timeout)"); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00, 8'h00); set_ready(0, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00); set_ready(1, 1'b0);
        tick; tick;
        checks += 5;
        if (in_ready1 !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready1); end
        if (out_valid1 !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid1); end
        if (busy1 !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0b exp 0", busy1); end
        if (product1 !== 16'h0000) begin errors++; $display("FAIL reset_product got %h exp 0000", product1); end
        if (rom_addr1 !== 8'h00)   begin errors++; $display("FAIL reset_rom_addr got %h exp 00", rom_addr1); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        logic [7:0] exp_addr [4];
        exp_addr = '{8'h24, 8'h23, 8'h14, 8'h13};
        drive(0, 1'b1, 8'h12, 8'h34);
        set_ready(0, 1'b1);
        tick;
        drive(0, 1'b0, 8'hEE, 8'hDD);
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (rom_addr1 !== exp_addr[i]) begin
                errors++; $display("FAIL basic_rom_addr[%0d] got %h exp %h", i, rom_addr1, exp_addr[i]);
            end
            if (out_valid1 !== 1'b0) begin
                errors++; $display("FAIL basic_early_valid[%0d] got %0b exp 0", i, out_valid1);
            end
            if (i < 3) tick;
        end
        tick;
        checks++;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL basic_valid_E4 got %0b exp 0", out_valid1); end
        tick;
        checks += 3;
        if (out_valid1 !== 1'b1)   begin errors++; $display("FAIL basic_valid_E5 got %0b exp 1", out_valid1); end
        if (product1 !== 16'h03A8) begin errors++; $display("FAIL basic_product got %h exp 03a8", product1); end
        if (busy1 !== 1'b1)        begin errors++; $display("FAIL basic_busy_done got %0b exp 1", busy1); end
        tick;
        checks += 2;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL basic_valid_after_hs got %0b exp 0", out_valid1); end
        if (in_ready1 !== 1'b1)  begin errors++; $display("FAIL basic_in_ready_after_hs got %0b exp 1", in_ready1); end
    endtask

    task automatic test_operands(input bit s, input int n_rand);
        logic [7:0] xs [$];
        logic [7:0] ys [$];
        logic [15:0] p, expv;
        int lat, exp_lat;
        exp_lat = s ? 6 : 5;
        if (s) begin xs = '{8'hAB, 8'hFF}; ys = '{8'hCD, 8'h01}; end
        else   begin xs = '{8'hFF, 8'h00, 8'h80}; ys = '{8'hFF, 8'hFF, 8'h02}; end
        for (int i = 0; i < n_rand; i++) begin
            xs.push_back(8'($urandom));
            ys.push_back(8'($urandom));
        end
        foreach (xs[i]) begin
            do_txn(s, xs[i], ys[i], p, lat);
            expv = 16'(xs[i]) * 16'(ys[i]);
            checks += 3;
            if (p !== expv) begin
                errors++; $display("FAIL op%0d_product %h*%h got %h exp %h", s, xs[i], ys[i], p, expv);
            end
            if (lat != exp_lat) begin
                errors++; $display("FAIL op%0d_latency %h*%h got %0d exp %0d", s, xs[i], ys[i], lat, exp_lat);
            end
            if (ir(s) !== 1'b1) begin
                errors++; $display("FAIL op%0d_in_ready_after_hs got %0b exp 1", s, ir(s));
            end
        end
    endtask

    task automatic test_backpressure;
        drive(0, 1'b1, 8'h12, 8'h34);
        set_ready(0, 1'b0);
        tick;
        drive(0, 1'b1, 8'h05, 8'h07);
        wait_ov(0);
        for (int i = 0; i < 3; i++) begin
            tick;
            checks += 3;
            if (out_valid1 !== 1'b1)   begin errors++; $display("FAIL bp_valid_hold[%0d] got %0b exp 1", i, out_valid1); end
            if (product1 !== 16'h03A8) begin errors++; $display("FAIL bp_product_hold[%0d] got %h exp 03a8", i, product1); end
            if (in_ready1 !== 1'b0)    begin errors++; $display("FAIL bp_in_ready[%0d] got %0b exp 0", i, in_ready1); end
        end
        set_ready(0, 1'b1);
        tick;
        checks += 3;
        if (out_valid1 !== 1'b0)   begin errors++; $display("FAIL bp_valid_after_hs got %0b exp 0", out_valid1); end
        if (in_ready1 !== 1'b1)    begin errors++; $display("FAIL bp_second_too_early got in_ready %0b exp 1", in_ready1); end
        if (product1 !== 16'h03A8) begin errors++; $display("FAIL bp_product_kept got %h exp 03a8", product1); end
        tick;
        drive(0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL bp_second_accept got busy %0b exp 1", busy1); end
        wait_ov(0);
        checks++;
        if (product1 !== 16'h0023) begin errors++; $display("FAIL bp_second_product got %h exp 0023", product1); end
        tick;
    endtask

    task automatic test_in_valid_during_run;
        logic [15:0] e1, e2;
        e1 = 16'(8'h21) * 16'(8'h13);
        e2 = 16'(8'h44) * 16'(8'h55);
        drive(0, 1'b1, 8'h21, 8'h13);
        set_ready(0, 1'b1);
        tick;
        drive(0, 1'b1, 8'h44, 8'h55);
        wait_ov(0);
        checks++;
        if (product1 !== e1) begin errors++; $display("FAIL ivrun_first got %h exp %h", product1, e1); end
        tick;
        checks++;
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL ivrun_idle got in_ready %0b exp 1", in_ready1); end
        tick;
        drive(0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL ivrun_second_accept got busy %0b exp 1", busy1); end
        wait_ov(0);
        checks++;
        if (product1 !== e2) begin errors++; $display("FAIL ivrun_second got %h exp %h", product1, e2); end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [15:0] p;
        int lat;
        bit seen;
        drive(0, 1'b1, 8'h99, 8'h77);
        set_ready(0, 1'b1);
        tick;
        drive(0, 1'b0, 8'h00, 8'h00);
        tick; tick;
        checks++;
        if (rom_addr1 !== 8'h97) begin errors++; $display("FAIL rmid_k2_addr got %h exp 97", rom_addr1); end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks += 4;
        if (in_ready1 !== 1'b1)    begin errors++; $display("FAIL rmid_in_ready got %0b exp 1", in_ready1); end
        if (out_valid1 !== 1'b0)   begin errors++; $display("FAIL rmid_out_valid got %0b exp 0", out_valid1); end
        if (product1 !== 16'h0000) begin errors++; $display("FAIL rmid_product got %h exp 0000", product1); end
        if (busy1 !== 1'b0)        begin errors++; $display("FAIL rmid_busy got %0b exp 0", busy1); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick; if (out_valid1) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL rmid_aborted_output got out_valid 1 exp 0"); end
        do_txn(0, 8'h0F, 8'h0F, p, lat);
        checks++;
        if (p !== 16'h00E1) begin errors++; $display("FAIL rmid_next_product got %h exp 00e1", p); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_operands(0, 12);
        test_backpressure;
        test_in_valid_during_run;
        test_reset_mid;
        test_operands(1, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
